complex_mxv_sequencer: RTL
==========================

# complex_mxv_sequencer

Controller that sequences a full complex matrix × vector product through the shared eight-lane complex dot-product unit (`complex_eight_Dot_Product_Multiply_with_control`). On `start` it walks rows 0..NOE-1. For each row it streams the row and vector chunks from the row/vector memories into the unit, waits for the unit's `finish`, and writes the scalar result into the result (AP) memory at the row index. It replaces ad-hoc per-module counters and write-enable pulsing with one deterministic FSM.

## Interface
Parameters:
- NOE, 16, equations (rows and vector length) per cluster
- NO_OF_UNITS, 8, lanes per beat
- ELEMENT_WIDTH, 64, complex element width, {real[63:32], imag[31:0]}
- ADDR_WIDTH, 8, memory address width
- BEATS (derived), ceil(NOE/NO_OF_UNITS), chunks per row

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle start request; ignored while busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last result write
- mem_rd_en  out  1  read strobe to the row and vector memories
- row_rd_addr  out  ADDR_WIDTH  row chunk address = row*BEATS + beat
- vec_rd_addr  out  ADDR_WIDTH  vector chunk address = beat
- row_rd_data  in  NO_OF_UNITS*ELEMENT_WIDTH  row chunk, valid 1 cycle after mem_rd_en
- vec_rd_data  in  NO_OF_UNITS*ELEMENT_WIDTH  vector chunk, same latency
- dp_row  out  NO_OF_UNITS*ELEMENT_WIDTH  registered row chunk to the unit
- dp_vec  out  NO_OF_UNITS*ELEMENT_WIDTH  registered vector chunk to the unit
- dp_valid  out  1  dp_row/dp_vec valid this cycle
- dp_last  out  1  marks the final beat of a row
- dp_result  in  ELEMENT_WIDTH  dot-product result
- dp_finish  in  1  result valid pulse from the unit
- res_we  out  1  result memory write enable, one cycle
- res_addr  out  ADDR_WIDTH  row index
- res_data  out  ELEMENT_WIDTH  captured dp_result

## Operation
- FSM states: IDLE, ISSUE, FILL, WAIT_DP, WRITE, DONE.
- IDLE: start=1 → ISSUE. Row=0, beat=0, busy=1 from the next cycle.
- ISSUE: mem_rd_en=1 for exactly BEATS consecutive cycles, with beat incrementing 0..BEATS-1. After the last beat → FILL.
- FILL: one cycle, draining the last registered chunk.
- Data path:
  - Each returned chunk is registered into dp_row/dp_vec.
  - dp_valid is high 2 cycles after the matching mem_rd_en.
  - dp_last is high on the beat with beat==BEATS-1.
- Padding: on the final beat, lanes with index beat*NO_OF_UNITS + lane ≥ NOE are forced to zero in both dp_row and dp_vec.
- WAIT_DP: wait for dp_finish. On dp_finish, res_data ← dp_result → WRITE.
- WRITE: res_we=1 and res_addr=row for one cycle.
  - row==NOE-1 → DONE.
  - Otherwise row+1, beat=0 → ISSUE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- dp_finish outside WAIT_DP is ignored; no write, no state change.
- start while busy is ignored. start in the same cycle as DONE is ignored; it is accepted from IDLE only.
- No timeout: the FSM stays in WAIT_DP until dp_finish arrives.

## Timing
- Reset value of all outputs is 0: busy, done, mem_rd_en, addresses, dp_*, res_*. The FSM goes to IDLE and the row and beat counters clear.
- Reset mid-operation:
  - Aborts immediately.
  - No res_we is issued in the reset cycle or after it.
  - A dp_finish arriving after reset is ignored.
- start accepted at edge T:
  - mem_rd_en is high in cycles T+1..T+BEATS.
  - dp_valid is high in cycles T+3..T+BEATS+2.
- Per-row latency = BEATS + 2 + L_dp + 1 cycles, where L_dp is measured from the last dp_valid to dp_finish.
- res_we is asserted in the cycle after the cycle in which dp_finish is sampled.
- done is asserted the cycle after the last res_we.
- Address arithmetic is unsigned and truncated to ADDR_WIDTH. Elaboration-time check: NOE*BEATS ≤ 2^ADDR_WIDTH.

## Structure
- Shared header complex_mxv_defs.vh holds:
  - state encodings (3-bit localparams)
  - the BEATS formula
  - the element field split (real/imag width 32)
- One sub-module, complex_lane_pad_mask: a combinational zero-mask of lanes ≥ NOE on the final beat. It is instantiated twice, once for row data and once for vector data.
- The FSM, counters and output registers live in the top module.

## Test plan
- NOE=16, NO_OF_UNITS=8. Unit model gives dp_finish 4 cycles after dp_last. Start →
  - 16 writes, res_addr 0..15 in order
  - res_data equal to the reference complex dot products
  - done exactly once
- NOE=12, NO_OF_UNITS=8: on the second beat, lanes 4..7 of dp_row/dp_vec are 0. Results match the unpadded 12-element products.
- Spurious dp_finish during ISSUE of row 0 → no res_we, FSM continues; the correct result is written only after the genuine dp_finish.
- start pulsed again at rows 3 and 9 → ignored; exactly 16 writes, one done.
- reset=0 asserted in WAIT_DP of row 5, then released →
  - outputs are 0
  - the late dp_finish causes no write
  - a new start restarts at row 0
- Row data all (1+1i), vector all (2+0i), NOE=16 → every res_data = 32+32i (real 32, imag 32).

Source files
------------

// File: rtl/complex_mxv_sequencer_pkg.sv
// Shared definitions for the complex matrix x vector sequencer: FSM encodings,
// chunk-count helper and complex element field split.
package complex_mxv_sequencer_pkg;

  // Real/imag half width of a complex element {real, imag}.
  localparam int unsigned PartWidth = 32;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StFill   = 3'd2,
    StWaitDp = 3'd3,
    StWrite  = 3'd4,
    StDone   = 3'd5
  } state_e;

  // Number of lane-wide chunks needed to cover one row.
  function automatic int unsigned calc_beats(input int unsigned noe, input int unsigned lanes);
    return (noe + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/complex_lane_pad_mask.sv
// Zeroes the lanes of the final chunk of a row that lie past the last element.
module complex_lane_pad_mask
  import complex_mxv_sequencer_pkg::*;
#(
  parameter int unsigned NOE           = 16,
  parameter int unsigned NO_OF_UNITS   = 8,
  parameter int unsigned ELEMENT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0]                beat_i,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] data_o
);

  localparam int unsigned Beats = calc_beats(NOE, NO_OF_UNITS);
  localparam logic [ADDR_WIDTH-1:0] LastBeat = ADDR_WIDTH'(Beats - 1);

  // Only the final beat can carry lanes beyond NOE.
  always_comb begin
    data_o = data_i;
    if (beat_i == LastBeat) begin
      for (int unsigned lane = 0; lane < NO_OF_UNITS; lane++) begin
        if ((Beats - 1) * NO_OF_UNITS + lane >= NOE) begin
          data_o[lane*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
        end
      end
    end
  end

endmodule

// File: rtl/complex_mxv_sequencer.sv
// Sequences a complex matrix x vector product row by row through a shared
// lane-parallel complex dot-product unit and writes each row result.
module complex_mxv_sequencer
  import complex_mxv_sequencer_pkg::*;
#(
  parameter int unsigned NOE           = 16,
  parameter int unsigned NO_OF_UNITS   = 8,
  parameter int unsigned ELEMENT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                row_rd_addr,
  output logic [ADDR_WIDTH-1:0]                vec_rd_addr,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] row_rd_data,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] vec_rd_data,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] dp_row,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] dp_vec,
  output logic                                 dp_valid,
  output logic                                 dp_last,
  input  logic [ELEMENT_WIDTH-1:0]             dp_result,
  input  logic                                 dp_finish,
  output logic                                 res_we,
  output logic [ADDR_WIDTH-1:0]                res_addr,
  output logic [ELEMENT_WIDTH-1:0]             res_data
);

  localparam int unsigned BEATS  = calc_beats(NOE, NO_OF_UNITS);
  localparam int unsigned ChunkW = NO_OF_UNITS * ELEMENT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BeatsA   = ADDR_WIDTH'(BEATS);
  localparam logic [ADDR_WIDTH-1:0] LastBeat = ADDR_WIDTH'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LastRow  = ADDR_WIDTH'(NOE - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  if (NOE * BEATS > (1 << ADDR_WIDTH)) begin : g_addr_check
    $error("row chunk addresses do not fit in ADDR_WIDTH");
  end
  if (ELEMENT_WIDTH != 2 * PartWidth) begin : g_elem_check
    $error("ELEMENT_WIDTH must hold a {real, imag} pair");
  end

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    row_q, row_d;
  logic [ADDR_WIDTH-1:0]    beat_q, beat_d;
  logic [ELEMENT_WIDTH-1:0] res_data_q, res_data_d;

  // Read-return stage: data from the memories is valid while rd_vld1_q is set.
  logic                     rd_vld1_q;
  logic [ADDR_WIDTH-1:0]    beat1_q;
  logic [ChunkW-1:0]        dp_row_q, dp_vec_q;
  logic                     dp_valid_q, dp_last_q;
  logic [ChunkW-1:0]        row_pad, vec_pad;

  complex_lane_pad_mask #(
    .NOE          (NOE),
    .NO_OF_UNITS  (NO_OF_UNITS),
    .ELEMENT_WIDTH(ELEMENT_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_row_pad (
    .data_i(row_rd_data),
    .beat_i(beat1_q),
    .data_o(row_pad)
  );

  complex_lane_pad_mask #(
    .NOE          (NOE),
    .NO_OF_UNITS  (NO_OF_UNITS),
    .ELEMENT_WIDTH(ELEMENT_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_vec_pad (
    .data_i(vec_rd_data),
    .beat_i(beat1_q),
    .data_o(vec_pad)
  );

  // State register, row/beat counters and captured result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      row_q      <= '0;
      beat_q     <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      beat_q     <= beat_d;
      res_data_q <= res_data_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    beat_d     = beat_q;
    res_data_d = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          row_d   = '0;
          beat_d  = '0;
        end
      end
      StIssue: begin
        if (beat_q == LastBeat) begin
          state_d = StFill;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + AddrOne;
        end
      end
      StFill:   state_d = StWaitDp;
      StWaitDp: begin
        if (dp_finish) begin
          res_data_d = dp_result;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (row_q == LastRow) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + AddrOne;
          beat_d  = '0;
          state_d = StIssue;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Decoded FSM outputs; all forced low while reset is held so nothing leaks out.
  always_comb begin
    busy        = reset && (state_q inside {StIssue, StFill, StWaitDp, StWrite});
    done        = reset && (state_q == StDone);
    mem_rd_en   = reset && (state_q == StIssue);
    res_we      = reset && (state_q == StWrite);
    row_rd_addr = mem_rd_en ? (row_q * BeatsA + beat_q) : '0;
    vec_rd_addr = mem_rd_en ? beat_q : '0;
    res_addr    = res_we ? row_q : '0;
    res_data    = res_data_q;
    dp_row      = dp_row_q;
    dp_vec      = dp_vec_q;
    dp_valid    = dp_valid_q;
    dp_last     = dp_last_q;
  end

  // Two-stage data path: memory return, then padded registered chunk to the unit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_vld1_q  <= 1'b0;
      beat1_q    <= '0;
      dp_row_q   <= '0;
      dp_vec_q   <= '0;
      dp_valid_q <= 1'b0;
      dp_last_q  <= 1'b0;
    end else begin
      rd_vld1_q  <= mem_rd_en;
      beat1_q    <= beat_q;
      dp_valid_q <= rd_vld1_q;
      dp_last_q  <= rd_vld1_q && (beat1_q == LastBeat);
      if (rd_vld1_q) begin
        dp_row_q <= row_pad;
        dp_vec_q <= vec_pad;
      end
    end
  end

endmodule
